dp_sqrt_round_pack: RTL

DP_SQRT_ROUND_PACK -- requirements
Module: dp_sqrt_round_pack

---
 rtl/dp_sqrt_pkg.sv | 34 +++
 rtl/dp_round_rne.sv | 21 ++
 rtl/dp_sqrt_round_pack.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dp_sqrt_pkg.sv
// Shared definitions for the double-precision square-root datapath.
// Holds the result-class encoding produced by the sqrt core, the IEEE-754
// binary64 field widths and the canonical special-value encodings. The
// upstream dp_sqrt wrapper and the round/pack stage both import this package
// so the class encoding has one definition.
package dp_sqrt_pkg;

    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
    localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;

    typedef enum logic [2:0] {
        CLS_NORMAL  = 3'd0,
        CLS_ZERO    = 3'd1,
        CLS_INF     = 3'd2,
        CLS_NAN     = 3'd3,
        CLS_INVALID = 3'd4
    } sqrt_class_e;

    // The three unused encodings are folded into NAN here, so downstream
    // logic only ever sees the five legal classes.
    function automatic sqrt_class_e decode_class(input logic [2:0] raw);
        case (raw)
            3'd0:    decode_class = CLS_NORMAL;
            3'd1:    decode_class = CLS_ZERO;
            3'd2:    decode_class = CLS_INF;
            3'd4:    decode_class = CLS_INVALID;
            default: decode_class = CLS_NAN;
        endcase
    endfunction

endpackage

// File: rtl/dp_round_rne.sv
// Round-to-nearest-even decision for a truncated significand.
// Ports:
//   lsb     - least significant kept fraction bit
//   guard   - first discarded bit
//   sticky  - OR of every bit below guard
//   inc     - add one ulp to the kept fraction
//   inexact - some nonzero bits were discarded
module dp_round_rne (
    input  logic lsb,
    input  logic guard,
    input  logic sticky,
    output logic inc,
    output logic inexact
);

    // Above half always rounds up; an exact half rounds up only when that
    // makes the kept fraction even.
    assign inc     = guard & (sticky | lsb);
    assign inexact = guard | sticky;

endmodule

// File: rtl/dp_sqrt_round_pack.sv
// Final rounding and packing stage of the binary64 square root.
// Takes the unrounded root from the sqrt core and produces an IEEE-754
// result with inexact/invalid flags. There are two register stages:
// S1 holds the rounding decision and S2 holds the packed result.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   in_valid/in_ready   - upstream handshake
//   in_sign, in_exp, in_root, in_rem_nz, in_class - core result fields
//   out_valid/out_ready - downstream handshake
//   out_result, out_inexact, out_invalid           - packed result and flags
module dp_sqrt_round_pack
    import dp_sqrt_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_root,
    input  logic              in_rem_nz,
    input  logic [2:0]        in_class,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_result,
    output logic              out_inexact,
    output logic              out_invalid
);

    logic              adv;

    logic              s1_valid_q;
    sqrt_class_e       s1_class_q;
    sqrt_class_e       s1_class_d;
    logic              s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic              s1_inc_q;
    logic              s1_inc_d;
    logic              s1_inexact_q;
    logic              s1_inexact_d;

    logic              out_valid_q;
    logic [63:0]       out_result_q;
    logic [63:0]       out_result_d;
    logic              out_inexact_q;
    logic              out_inexact_d;
    logic              out_invalid_q;
    logic              out_invalid_d;

    logic              unused_hidden_bit;

    // The hidden one is implied by a normal result and never stored.
    assign unused_hidden_bit = in_root[FRAC_W+1];

    // Both stages move together; a stalled S2 freezes S1 too, so the
    // pipeline never needs a skid buffer and never drops a result.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    assign s1_class_d = decode_class(in_class);

    dp_round_rne u_round (
        .lsb     (in_root[1]),
        .guard   (in_root[0]),
        .sticky  (in_rem_nz),
        .inc     (s1_inc_d),
        .inexact (s1_inexact_d)
    );

    // S1: capture the kept fields and the rounding decision. Payload is
    // only loaded on a real transfer so idle inputs never disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_class_q   <= CLS_NORMAL;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= '0;
            s1_frac_q    <= '0;
            s1_inc_q     <= 1'b0;
            s1_inexact_q <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_class_q   <= s1_class_d;
                s1_sign_q    <= in_sign;
                s1_exp_q     <= in_exp;
                s1_frac_q    <= in_root[FRAC_W:1];
                s1_inc_q     <= s1_inc_d;
                s1_inexact_q <= s1_inexact_d;
            end
        end
    end

    // Pack the S1 contents into a binary64 word. For normal results the
    // increment is applied to {exp, frac} as one field so that a carry out
    // of an all-ones fraction lands in the exponent automatically.
    always_comb begin
        out_result_d  = '0;
        out_inexact_d = 1'b0;
        out_invalid_d = 1'b0;
        case (s1_class_q)
            CLS_NORMAL: begin
                out_result_d  = {1'b0, {s1_exp_q, s1_frac_q} + {62'b0, s1_inc_q}};
                out_inexact_d = s1_inexact_q;
            end
            CLS_ZERO: begin
                out_result_d = {s1_sign_q, 63'b0};
            end
            CLS_INF: begin
                out_result_d = PINF;
            end
            CLS_INVALID: begin
                out_result_d  = QNAN;
                out_invalid_d = 1'b1;
            end
            default: begin
                out_result_d = QNAN;
            end
        endcase
    end

    // S2: the output register. Holding it while stalled keeps the
    // presented result and flags stable until downstream takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_inexact_q <= 1'b0;
            out_invalid_q <= 1'b0;
        end else if (adv) begin
            out_valid_q   <= s1_valid_q;
            out_result_q  <= out_result_d;
            out_inexact_q <= out_inexact_d;
            out_invalid_q <= out_invalid_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_inexact = out_inexact_q;
    assign out_invalid = out_invalid_q;

endmodule
